// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the operand fetch unit.
//   - fetch_state_e : layer-level FSM states
//   - DEF_*         : default parameter values for operand_fetch_unit
//   - count_ones    : population count of an in-flight valid shift register
package fetch_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_MEM_LATENCY = 2;
    localparam int DEF_FIFO_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    // Latency shift registers are at most 4 deep; callers zero-extend.
    function automatic int count_ones(input logic [3:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with simultaneous push/pop and flush.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : empty the FIFO (wins over push/pop)
//   push, wdata     : write request and data
//   pop             : read request; rdata is the current head
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        rdata    = mem_q[rd_ptr_q];
        do_pop   = pop && !empty;
        // A pop frees the slot this cycle, so a full FIFO may still accept.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever read out.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: accepts IFM/filter addresses from the address generator,
// issues fixed-latency SRAM reads, buffers returns in one FIFO per channel and
// presents paired operands to the PE array.
// Ports:
//   clk, rst_n                          : clock, synchronous active-low reset
//   start                               : pulse that begins a layer (IDLE only)
//   req_addr_in_*, addr_valid_*         : per-channel address from generator
//   done_compute                        : generator finished (RUN only)
//   addr_ready                          : shared ready back to the generator
//   mem_rd_en_*, mem_addr_*, mem_rdata_*: SRAM read ports
//   pe_data_*, pe_valid, pe_ready       : paired operand stream to PEs
//   fetch_done                          : one-cycle pulse in DONE
//   err_unpaired                        : sticky, leftover unpaired data at end
//   dbg_state                           : current FSM state (fetch_state_e)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready, and data is held while valid && !ready.
module operand_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] req_addr_in_ifm,
    input  logic [ADDR_WIDTH-1:0] req_addr_in_filter,
    input  logic                  addr_valid_ifm,
    input  logic                  addr_valid_filter,
    input  logic                  done_compute,
    output logic                  addr_ready,
    output logic                  mem_rd_en_ifm,
    output logic                  mem_rd_en_filter,
    output logic [ADDR_WIDTH-1:0] mem_addr_ifm,
    output logic [ADDR_WIDTH-1:0] mem_addr_filter,
    input  logic [DATA_WIDTH-1:0] mem_rdata_ifm,
    input  logic [DATA_WIDTH-1:0] mem_rdata_filter,
    output logic [DATA_WIDTH-1:0] pe_data_ifm,
    output logic [DATA_WIDTH-1:0] pe_data_filter,
    output logic                  pe_valid,
    input  logic                  pe_ready,
    output logic                  fetch_done,
    output logic                  err_unpaired,
    output logic [1:0]            dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e           state_q, state_d;
    logic [MEM_LATENCY-1:0] vld_ifm_q, vld_ifm_d;
    logic [MEM_LATENCY-1:0] vld_flt_q, vld_flt_d;
    logic                   err_q, err_d;

    logic                   acc_ifm, acc_flt;
    logic                   push_ifm, push_flt, pop, flush;
    logic                   credit_ifm, credit_flt, in_flight;
    logic [DATA_WIDTH-1:0]  head_ifm, head_flt;
    logic                   full_ifm, full_flt, empty_ifm, empty_flt;
    logic [CW-1:0]          cnt_ifm, cnt_flt;

    always_comb begin
        // Credit: everything already committed (in flight + buffered) must
        // leave a spare slot, so the FIFO can never be forced to overflow.
        credit_ifm = (count_ones(4'(vld_ifm_q)) + int'(cnt_ifm)) < (FIFO_DEPTH - 1);
        credit_flt = (count_ones(4'(vld_flt_q)) + int'(cnt_flt)) < (FIFO_DEPTH - 1);
        addr_ready = (state_q == ST_RUN) && credit_ifm && credit_flt;

        acc_ifm          = addr_ready && addr_valid_ifm;
        acc_flt          = addr_ready && addr_valid_filter;
        mem_rd_en_ifm    = acc_ifm;
        mem_rd_en_filter = acc_flt;
        mem_addr_ifm     = acc_ifm ? req_addr_in_ifm    : '0;
        mem_addr_filter  = acc_flt ? req_addr_in_filter : '0;

        // Bit k set means a read issued k+1 cycles ago; the top bit marks
        // the cycle in which mem_rdata carries that read's data.
        vld_ifm_d    = vld_ifm_q << 1;
        vld_ifm_d[0] = acc_ifm;
        vld_flt_d    = vld_flt_q << 1;
        vld_flt_d[0] = acc_flt;
        in_flight    = (|vld_ifm_q) || (|vld_flt_q);

        pe_valid       = !empty_ifm && !empty_flt;
        pop            = pe_valid && pe_ready;
        pe_data_ifm    = pe_valid ? head_ifm : '0;
        pe_data_filter = pe_valid ? head_flt : '0;
        push_ifm       = vld_ifm_q[MEM_LATENCY-1] && (!full_ifm || pop);
        push_flt       = vld_flt_q[MEM_LATENCY-1] && (!full_flt || pop);

        state_d = state_q;
        err_d   = err_q;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (done_compute) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!in_flight) begin
                    if (empty_ifm && empty_flt) begin
                        state_d = ST_DONE;
                    end else if (empty_ifm != empty_flt) begin
                        // Leftover data with no partner can never be paired.
                        err_d   = 1'b1;
                        flush   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        fetch_done   = (state_q == ST_DONE);
        err_unpaired = err_q;
        dbg_state    = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vld_ifm_q <= '0;
            vld_flt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_ifm_q <= vld_ifm_d;
            vld_flt_q <= vld_flt_d;
            err_q     <= err_d;
        end
    end

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_ifm (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_ifm),
        .wdata (mem_rdata_ifm),
        .pop   (pop),
        .rdata (head_ifm),
        .full  (full_ifm),
        .empty (empty_ifm),
        .count (cnt_ifm)
    );

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_flt (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_flt),
        .wdata (mem_rdata_filter),
        .pop   (pop),
        .rdata (head_flt),
        .full  (full_flt),
        .empty (empty_flt),
        .count (cnt_flt)
    );

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Testbench for operand_fetch_unit: SRAM model returning data = address after
// a fixed latency, a reference model of accepted-but-unconsumed operands per
// channel with their earliest visibility cycle, and scenario tasks.
module tb_operand_fetch_unit;
    import fetch_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 8;

    logic          clk, rst_n, start, done_compute, pe_ready;
    logic          addr_valid_ifm, addr_valid_filter;
    logic [AW-1:0] req_addr_in_ifm, req_addr_in_filter;
    logic          addr_ready, mem_rd_en_ifm, mem_rd_en_filter;
    logic [AW-1:0] mem_addr_ifm, mem_addr_filter;
    logic [DW-1:0] mem_rdata_ifm, mem_rdata_filter, pe_data_ifm, pe_data_filter;
    logic          pe_valid, fetch_done, err_unpaired;
    logic [1:0]    dbg_state;

    operand_fetch_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .req_addr_in_ifm(req_addr_in_ifm), .req_addr_in_filter(req_addr_in_filter),
        .addr_valid_ifm(addr_valid_ifm), .addr_valid_filter(addr_valid_filter),
        .done_compute(done_compute), .addr_ready(addr_ready),
        .mem_rd_en_ifm(mem_rd_en_ifm), .mem_rd_en_filter(mem_rd_en_filter),
        .mem_addr_ifm(mem_addr_ifm), .mem_addr_filter(mem_addr_filter),
        .mem_rdata_ifm(mem_rdata_ifm), .mem_rdata_filter(mem_rdata_filter),
        .pe_data_ifm(pe_data_ifm), .pe_data_filter(pe_data_filter),
        .pe_valid(pe_valid), .pe_ready(pe_ready),
        .fetch_done(fetch_done), .err_unpaired(err_unpaired), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model: data = address, LAT cycles later ----------------
    // Idle slots carry random garbage so stray writes would be visible.
    logic [AW-1:0] sram_ifm_pipe [LAT];
    logic [AW-1:0] sram_flt_pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            sram_ifm_pipe[i] <= sram_ifm_pipe[i-1];
            sram_flt_pipe[i] <= sram_flt_pipe[i-1];
        end
        sram_ifm_pipe[0] <= mem_rd_en_ifm    ? mem_addr_ifm    : AW'($urandom);
        sram_flt_pipe[0] <= mem_rd_en_filter ? mem_addr_filter : AW'($urandom);
    end
    assign mem_rdata_ifm    = sram_ifm_pipe[LAT-1];
    assign mem_rdata_filter = sram_flt_pipe[LAT-1];

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_ifm_q[$];
    logic [DW-1:0] exp_flt_q[$];
    int            arr_ifm_q[$];   // first cycle the operand may be presented
    int            arr_flt_q[$];
    int            out_ifm = 0;    // accepted minus consumed, per channel
    int            out_flt = 0;
    int            m_phase = 0;    // 0 idle, 1 accepting, 2 finishing
    int            beats = 0;
    int            fd_count = 0;
    int            first_acc_cyc = -1;
    int            first_beat_cyc = -1;
    logic          fd_prev = 1'b0;

    always @(negedge clk) begin
        logic exp_ready, exp_pv;
        if (!rst_n) begin
            exp_ifm_q.delete(); exp_flt_q.delete();
            arr_ifm_q.delete(); arr_flt_q.delete();
            out_ifm = 0; out_flt = 0; m_phase = 0; fd_prev = 1'b0;
        end else begin
            exp_ready = (m_phase == 1) && (out_ifm < DEPTH - 1) && (out_flt < DEPTH - 1);
            n_checks++;
            if (addr_ready !== exp_ready) begin
                n_errors++;
                $display("FAIL addr_ready cyc=%0d got=%b exp=%b out_ifm=%0d out_flt=%0d",
                         cyc, addr_ready, exp_ready, out_ifm, out_flt);
            end

            n_checks++;
            if (addr_valid_ifm && addr_ready) begin
                if (mem_rd_en_ifm !== 1'b1 || mem_addr_ifm !== req_addr_in_ifm) begin
                    n_errors++;
                    $display("FAIL mem_rd_ifm cyc=%0d en=%b addr=%h exp_addr=%h",
                             cyc, mem_rd_en_ifm, mem_addr_ifm, req_addr_in_ifm);
                end
                exp_ifm_q.push_back(req_addr_in_ifm);
                arr_ifm_q.push_back(cyc + LAT + 1);
                out_ifm++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end else if (mem_rd_en_ifm !== 1'b0) begin
                n_errors++;
                $display("FAIL mem_rd_ifm_idle cyc=%0d en=%b exp=0", cyc, mem_rd_en_ifm);
            end

            n_checks++;
            if (addr_valid_filter && addr_ready) begin
                if (mem_rd_en_filter !== 1'b1 || mem_addr_filter !== req_addr_in_filter) begin
                    n_errors++;
                    $display("FAIL mem_rd_flt cyc=%0d en=%b addr=%h exp_addr=%h",
                             cyc, mem_rd_en_filter, mem_addr_filter, req_addr_in_filter);
                end
                exp_flt_q.push_back(req_addr_in_filter);
                arr_flt_q.push_back(cyc + LAT + 1);
                out_flt++;
            end else if (mem_rd_en_filter !== 1'b0) begin
                n_errors++;
                $display("FAIL mem_rd_flt_idle cyc=%0d en=%b exp=0", cyc, mem_rd_en_filter);
            end

            exp_pv = 1'b0;
            if (exp_ifm_q.size() > 0 && exp_flt_q.size() > 0) begin
                if (arr_ifm_q[0] <= cyc && arr_flt_q[0] <= cyc) exp_pv = 1'b1;
            end
            n_checks++;
            if (pe_valid !== exp_pv) begin
                n_errors++;
                $display("FAIL pe_valid cyc=%0d got=%b exp=%b", cyc, pe_valid, exp_pv);
            end else if (exp_pv) begin
                n_checks++;
                if (pe_data_ifm !== exp_ifm_q[0] || pe_data_filter !== exp_flt_q[0]) begin
                    n_errors++;
                    $display("FAIL pe_data cyc=%0d got=%h/%h exp=%h/%h", cyc,
                             pe_data_ifm, pe_data_filter, exp_ifm_q[0], exp_flt_q[0]);
                end
                if (pe_ready) begin
                    void'(exp_ifm_q.pop_front()); void'(exp_flt_q.pop_front());
                    void'(arr_ifm_q.pop_front()); void'(arr_flt_q.pop_front());
                    out_ifm--; out_flt--; beats++;
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                end
            end

            if (fetch_done) begin
                n_checks++;
                if (fd_prev) begin
                    n_errors++;
                    $display("FAIL fetch_done_width cyc=%0d got=2+ cycles exp=1", cyc);
                end
            end

            // Phase bookkeeping for the next cycle.
            if (m_phase == 0 && start) m_phase = 1;
            else if (m_phase == 1 && done_compute) m_phase = 2;
            if (fetch_done && !fd_prev) begin
                fd_count++;
                m_phase = 0;
                // Leftovers of a finished layer are discarded.
                exp_ifm_q.delete(); exp_flt_q.delete();
                arr_ifm_q.delete(); arr_flt_q.delete();
                out_ifm = 0; out_flt = 0;
            end
            fd_prev = fetch_done;
        end
    end

    // ---------------- driver ----------------
    int   bp_unstable;
    logic bp_end_ready;
    int   bp_end_out_ifm, bp_end_out_flt;

    task automatic idle_inputs();
        start = 1'b0; done_compute = 1'b0; pe_ready = 1'b0;
        addr_valid_ifm = 1'b0; addr_valid_filter = 1'b0;
        req_addr_in_ifm = '0; req_addr_in_filter = '0;
    endtask

    // One full layer: start, stream n_ifm/n_flt consecutive addresses, then
    // done_compute, then wait (bounded) for fetch_done.
    task automatic run_layer(input logic [AW-1:0] ifm_base, input logic [AW-1:0] flt_base,
                             input int n_ifm, input int n_flt, input int flt_delay,
                             input int valid_pct, input int ready_pct,
                             input int stall_at, input int stall_len, output int got_done);
        int i_idx = 0, f_idx = 0, c = 0, fd0;
        logic dc_sent = 1'b0;
        logic held_v = 1'b0;
        logic [DW-1:0] held_i = '0, held_f = '0;
        fd0 = fd_count;
        first_acc_cyc = -1; first_beat_cyc = -1; beats = 0;
        bp_unstable = 0; bp_end_ready = 1'bx; bp_end_out_ifm = -1; bp_end_out_flt = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (c < 3000 && fd_count == fd0) begin
            if (stall_len > 0 && c == stall_at + stall_len) begin
                bp_end_ready = addr_ready;
                bp_end_out_ifm = out_ifm;
                bp_end_out_flt = out_flt;
            end
            addr_valid_ifm    = (i_idx < n_ifm) && ($urandom_range(99) < valid_pct);
            req_addr_in_ifm   = ifm_base + AW'(i_idx);
            addr_valid_filter = (f_idx < n_flt) && (c >= flt_delay) && ($urandom_range(99) < valid_pct);
            req_addr_in_filter = flt_base + AW'(f_idx);
            done_compute = 1'b0;
            if (i_idx >= n_ifm && f_idx >= n_flt && !dc_sent) begin
                done_compute = 1'b1;
                dc_sent = 1'b1;
            end
            if (stall_len > 0 && c >= stall_at && c < stall_at + stall_len) pe_ready = 1'b0;
            else pe_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (addr_valid_ifm && addr_ready) i_idx++;
            if (addr_valid_filter && addr_ready) f_idx++;
            if (!pe_ready && pe_valid) begin
                if (held_v && (pe_data_ifm !== held_i || pe_data_filter !== held_f)) bp_unstable++;
                held_v = 1'b1; held_i = pe_data_ifm; held_f = pe_data_filter;
            end else begin
                held_v = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        idle_inputs();
        got_done = (fd_count > fd0) ? 1 : 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({addr_ready, mem_rd_en_ifm, mem_rd_en_filter, pe_valid, fetch_done, err_unpaired} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got=%b%b%b%b%b%b exp=000000", addr_ready, mem_rd_en_ifm,
                     mem_rd_en_filter, pe_valid, fetch_done, err_unpaired);
        end
        n_checks++;
        if ({mem_addr_ifm, mem_addr_filter, pe_data_ifm, pe_data_filter} !== '0) begin
            n_errors++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", mem_addr_ifm, mem_addr_filter,
                     pe_data_ifm, pe_data_filter);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        int got;
        run_layer('0, '0, 16, 16, 0, 100, 100, 0, 0, got);
        n_checks++;
        if (got !== 1) begin n_errors++; $display("FAIL basic_done got=%0d exp=1", got); end
        n_checks++;
        if (beats !== 16) begin n_errors++; $display("FAIL basic_beats got=%0d exp=16", beats); end
        n_checks++;
        if (first_beat_cyc - first_acc_cyc !== LAT + 1) begin
            n_errors++;
            $display("FAIL basic_latency got=%0d exp=%0d", first_beat_cyc - first_acc_cyc, LAT + 1);
        end
        n_checks++;
        if (err_unpaired !== 1'b0) begin n_errors++; $display("FAIL basic_err got=%b exp=0", err_unpaired); end
    endtask

    task automatic test_backpressure();
        int got;
        run_layer(32'h100, 32'h200, 40, 40, 0, 100, 100, 2, 20, got);
        n_checks++;
        if (bp_end_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready got=%b exp=0", bp_end_ready); end
        n_checks++;
        if (bp_end_out_ifm !== DEPTH - 1 || bp_end_out_flt !== DEPTH - 1) begin
            n_errors++;
            $display("FAIL bp_outstanding got=%0d/%0d exp=%0d", bp_end_out_ifm, bp_end_out_flt, DEPTH - 1);
        end
        n_checks++;
        if (bp_unstable !== 0) begin n_errors++; $display("FAIL bp_stable got=%0d changes exp=0", bp_unstable); end
        n_checks++;
        if (beats !== 40 || got !== 1) begin
            n_errors++;
            $display("FAIL bp_beats got=%0d done=%0d exp=40 done=1", beats, got);
        end
    endtask

    task automatic test_skew();
        int got;
        run_layer(32'h300, 32'h400, 16, 16, 3, 100, 100, 0, 0, got);
        n_checks++;
        if (beats !== 16 || got !== 1) begin
            n_errors++;
            $display("FAIL skew_beats got=%0d done=%0d exp=16 done=1", beats, got);
        end
    endtask

    task automatic test_unpaired();
        int got;
        run_layer(32'h500, 32'h600, 5, 4, 0, 100, 100, 0, 0, got);
        n_checks++;
        if (beats !== 4) begin n_errors++; $display("FAIL unpaired_beats got=%0d exp=4", beats); end
        n_checks++;
        if (got !== 1) begin n_errors++; $display("FAIL unpaired_done got=%0d exp=1", got); end
        n_checks++;
        if (err_unpaired !== 1'b1) begin n_errors++; $display("FAIL unpaired_err got=%b exp=1", err_unpaired); end
    endtask

    task automatic test_start_rules();
        int fd0, w;
        @(posedge clk); #1 done_compute = 1'b1;
        @(posedge clk); #1 done_compute = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_IDLE || err_unpaired !== 1'b1) begin
            n_errors++;
            $display("FAIL dc_in_idle state=%0d err=%b exp state=0 err=1", dbg_state, err_unpaired);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_RUN || err_unpaired !== 1'b0) begin
            n_errors++;
            $display("FAIL start_clears state=%0d err=%b exp state=1 err=0", dbg_state, err_unpaired);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_RUN) begin
            n_errors++;
            $display("FAIL start_in_run state=%0d exp=1", dbg_state);
        end
        fd0 = fd_count;
        @(posedge clk); #1 done_compute = 1'b1;
        @(posedge clk); #1 done_compute = 1'b0;
        w = 0;
        while (fd_count == fd0 && w < 20) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (fd_count !== fd0 + 1) begin
            n_errors++;
            $display("FAIL empty_layer_done got=%0d pulses exp=1", fd_count - fd0);
        end
    endtask

    task automatic test_reset_midstream();
        int got;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        addr_valid_ifm = 1'b1; addr_valid_filter = 1'b1;
        req_addr_in_ifm = 32'h700; req_addr_in_filter = 32'h800;
        @(posedge clk); #1 req_addr_in_ifm = 32'h701; req_addr_in_filter = 32'h801;
        @(posedge clk); #1 addr_valid_ifm = 1'b0; addr_valid_filter = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({addr_ready, mem_rd_en_ifm, mem_rd_en_filter, pe_valid, fetch_done, err_unpaired} !== 6'b0 ||
            dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL midreset_ctrl got=%b%b%b%b%b%b state=%0d exp=000000 state=0", addr_ready,
                     mem_rd_en_ifm, mem_rd_en_filter, pe_valid, fetch_done, err_unpaired, dbg_state);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (pe_valid !== 1'b0 || pe_data_ifm !== '0 || pe_data_filter !== '0) begin
                n_errors++;
                $display("FAIL stale_return k=%0d pe_valid=%b data=%h/%h exp=0", k, pe_valid,
                         pe_data_ifm, pe_data_filter);
            end
        end
        run_layer(32'h900, 32'hA00, 10, 10, 0, 80, 80, 0, 0, got);
        n_checks++;
        if (beats !== 10 || got !== 1) begin
            n_errors++;
            $display("FAIL post_reset_layer got=%0d done=%0d exp=10 done=1", beats, got);
        end
    endtask

    task automatic test_random();
        int got, n, skew;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(24, 1);
            skew = $urandom_range(4, 0);
            run_layer(AW'($urandom), AW'($urandom), n, n, skew,
                      $urandom_range(100, 30), $urandom_range(100, 30), 0, 0, got);
            n_checks++;
            if (beats !== n || got !== 1 || err_unpaired !== 1'b0) begin
                n_errors++;
                $display("FAIL random_%0d beats=%0d done=%0d err=%b exp beats=%0d done=1 err=0",
                         it, beats, got, err_unpaired, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_skew();
        test_unpaired();
        test_start_rules();
        test_reset_midstream();
        test_random();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of IFM/filter data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the width of IFM/filter addresses.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, the fixed SRAM read latency in cycles (legal range 1..4).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, the entries per data FIFO (power of 2, 4..32).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins a layer.
REQ-008 SHALL have ports req_addr_in_ifm / req_addr_in_filter, input, ADDR_WIDTH each: address-generator outputs.
REQ-009 SHALL have ports addr_valid_ifm / addr_valid_filter, input, 1 bit each: per-channel address valid.
REQ-010 SHALL have port done_compute, input, 1 bit: address generator finished issuing.
REQ-011 SHALL have port addr_ready, output, 1 bit: drives the generator's ready input.
REQ-012 SHALL have ports mem_rd_en_ifm / mem_rd_en_filter, output, 1 bit each: SRAM read strobes.
REQ-013 SHALL have ports mem_addr_ifm / mem_addr_filter, output, ADDR_WIDTH each: SRAM read addresses.
REQ-014 SHALL have ports mem_rdata_ifm / mem_rdata_filter, input, DATA_WIDTH each: SRAM read data.
REQ-015 SHALL have ports pe_data_ifm / pe_data_filter, output, DATA_WIDTH each: paired operands to the PE array.
REQ-016 SHALL have ports pe_valid (output) and pe_ready (input), 1 bit each: PE handshake.
REQ-017 SHALL have ports fetch_done (output, 1-bit pulse) and err_unpaired (output, 1 bit, sticky).

Function
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when done_compute=1; DRAIN->DONE when nothing is in flight and both FIFOs are empty; DONE->IDLE after one cycle.
REQ-019 SHALL accept a channel address when its addr_valid=1, addr_ready=1 and state is RUN (or the RUN->DRAIN transition cycle); channels are accepted independently.
REQ-020 SHALL drive addr_ready=1 only in RUN and only when, for each channel, in-flight reads plus FIFO occupancy < FIFO_DEPTH-1 (credit check, so a pop can never be required to avoid overflow).
REQ-021 SHALL drive mem_rd_en_x and mem_addr_x combinationally in the accept cycle t, and write mem_rdata_x into that channel's FIFO at the end of cycle t+MEM_LATENCY, tracked by a MEM_LATENCY-deep valid shift register.
REQ-022 SHALL drive pe_valid=1 when both FIFOs are non-empty; pe_data_* are the FIFO heads; both FIFOs pop together when pe_valid and pe_ready are both 1. The minimum address-to-pe_valid latency is MEM_LATENCY+1 cycles, with no bypass.
REQ-023 SHALL hold pe_data_* stable while pe_valid=1 and pe_ready=0.
REQ-024 SHALL support push and pop on the same FIFO in the same cycle, with occupancy unchanged.
REQ-025 SHALL, in DRAIN with nothing in flight, one FIFO non-empty and the other empty, set err_unpaired=1, flush both FIFOs and enter DONE.
REQ-026 SHALL pulse fetch_done=1 for exactly the DONE cycle.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL ignore done_compute outside RUN.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, enter IDLE, clear both FIFOs, the valid shift registers and the credit counters, and drive addr_ready=0, mem_rd_en_*=0, pe_valid=0, fetch_done=0 and err_unpaired=0; mem_addr_* and pe_data_* are 0.
REQ-030 SHALL discard in-flight SRAM returns when reset is applied mid-operation; returns arriving after reset are not written.
REQ-031 SHALL clear err_unpaired only on reset or on start.

Structure
REQ-032 SHALL take the FSM state enum and default parameter constants from shared package fetch_pkg.
REQ-033 SHALL instantiate sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/count) twice, once per channel.

Verification
REQ-034 SHALL cover basic flow: start, 16 paired addresses 0x00..0x0F, SRAM data = address, pe_ready=1 -> 16 pe_valid beats with ifm==filter==0x00..0x0F, first beat 3 cycles after the first accept (MEM_LATENCY=2), then one fetch_done pulse.
REQ-035 SHALL cover backpressure: pe_ready=0 for 20 cycles during the stream -> addr_ready falls once 7 per channel are outstanding, no FIFO overflow, pe_data stable, and no data lost after release.
REQ-036 SHALL cover skewed channels: filter valid lagging ifm by 3 cycles -> pairs are still emitted in order and pe_valid only when both heads are present.
REQ-037 SHALL cover unpaired data: 5 ifm and 4 filter addresses, then done_compute -> 4 beats, err_unpaired=1, fetch_done pulses.
REQ-038 SHALL cover reset mid-stream: rst_n=0 for 1 cycle with 2 reads in flight -> all outputs at reset values, and stale returns never appear on pe_data.
